// File: rtl/game_sequencer.sv
// Game-flow controller: walks the level instances through title, load,
// play, result-hold and end screens.  It picks the active level, drives that
// level's active-low reset, tracks remaining lives and advances the level
// index on a win.  Every output is a register; the next-state logic below
// also computes the next output values so they change together with the state.
module game_sequencer #(
    parameter int NUM_LEVELS    = 3,
    parameter int LIVES         = 3,
    parameter int LOAD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 25_000_000,
    localparam int SEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int LV_W  = (LIVES > 0) ? $clog2(LIVES + 1) : 1
) (
    input  logic             vga_clock,
    input  logic             reset,
    input  logic             start_button,
    input  logic             level_win,
    input  logic             level_lose,
    output logic [SEL_W-1:0] level_select,
    output logic             level_reset_n,
    output logic [1:0]       screen_mode,
    output logic [LV_W-1:0]  lives,
    output logic             game_won,
    output logic             game_over
);

    typedef enum logic [2:0] {
        ST_TITLE,
        ST_LOAD,
        ST_PLAY,
        ST_WIN_HOLD,
        ST_LOSE_HOLD,
        ST_VICTORY,
        ST_GAME_OVER
    } state_t;

    // Terminal counts for the shared 32-bit timer.
    localparam logic [31:0]      LOAD_LAST  = 32'(LOAD_CYCLES - 1);
    localparam logic [31:0]      HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]      SETTLE_LEN = 32'(SETTLE_CYCLES);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_LEVELS - 1);
    localparam logic [LV_W-1:0]  LIVES_INIT = LV_W'(LIVES);

    state_t            state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [LV_W-1:0]   lives_q, lives_d;
    logic              start_q;
    logic              start_rise;
    logic              level_reset_n_q, level_reset_n_d;
    logic [1:0]        screen_mode_q, screen_mode_d;
    logic              game_won_q, game_won_d;
    logic              game_over_q, game_over_d;

    // A start press acts only on its first cycle; because the edge lasts one
    // cycle it is naturally consumed by whichever transition it triggers.
    assign start_rise = start_button & ~start_q;

    // Next-state, timer, level index and lives; registered output values are
    // decoded from the next state so they line up with it.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q + 32'd1;
        sel_d           = sel_q;
        lives_d         = lives_q;
        level_reset_n_d = 1'b0;
        screen_mode_d   = 2'd0;
        game_won_d      = 1'b0;
        game_over_d     = 1'b0;

        case (state_q)
            ST_TITLE: begin
                timer_d = '0;
                if (start_rise) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (timer_q == LOAD_LAST) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Stop counting once settled so the flags are never masked again.
                timer_d = (timer_q < SETTLE_LEN) ? timer_q + 32'd1 : timer_q;
                if (timer_q >= SETTLE_LEN) begin
                    if (level_lose) begin
                        state_d = ST_LOSE_HOLD;
                        lives_d = (lives_q == '0) ? '0 : lives_q - LV_W'(1);
                    end else if (level_win) begin
                        state_d = ST_WIN_HOLD;
                    end
                end
            end
            ST_WIN_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    if (sel_q == SEL_LAST) begin
                        state_d = ST_VICTORY;
                    end else begin
                        state_d = ST_LOAD;
                        sel_d   = sel_q + SEL_W'(1);
                    end
                end
            end
            ST_LOSE_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = (lives_q == '0) ? ST_GAME_OVER : ST_LOAD;
                end
            end
            ST_VICTORY, ST_GAME_OVER: begin
                timer_d = '0;
                if (start_rise) begin
                    state_d = ST_LOAD;
                    sel_d   = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase

        // Every state change restarts the timer from zero.
        if (state_d != state_q) begin
            timer_d = '0;
        end

        case (state_d)
            ST_LOAD: begin
                screen_mode_d = 2'd1;
            end
            ST_PLAY: begin
                screen_mode_d   = 2'd1;
                level_reset_n_d = 1'b1;
            end
            ST_WIN_HOLD: begin
                screen_mode_d   = 2'd2;
                level_reset_n_d = 1'b1;
            end
            ST_LOSE_HOLD: begin
                screen_mode_d   = 2'd3;
                level_reset_n_d = 1'b1;
            end
            ST_VICTORY: begin
                screen_mode_d = 2'd2;
                game_won_d    = 1'b1;
            end
            ST_GAME_OVER: begin
                screen_mode_d = 2'd3;
                game_over_d   = 1'b1;
            end
            default: begin
                screen_mode_d = 2'd0;
            end
        endcase
    end

    // State, counters and registered outputs, with synchronous reset.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q         <= ST_TITLE;
            timer_q         <= '0;
            sel_q           <= '0;
            lives_q         <= LIVES_INIT;
            start_q         <= 1'b0;
            level_reset_n_q <= 1'b0;
            screen_mode_q   <= 2'd0;
            game_won_q      <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            sel_q           <= sel_d;
            lives_q         <= lives_d;
            start_q         <= start_button;
            level_reset_n_q <= level_reset_n_d;
            screen_mode_q   <= screen_mode_d;
            game_won_q      <= game_won_d;
            game_over_q     <= game_over_d;
        end
    end

    assign level_select  = sel_q;
    assign lives         = lives_q;
    assign level_reset_n = level_reset_n_q;
    assign screen_mode   = screen_mode_q;
    assign game_won      = game_won_q;
    assign game_over     = game_over_q;

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller: sequences the level modules through title, load, play, result-hold and end screens.
- Selects which level drives the renderer and generates each level's active-low reset.
- Counts remaining lives and advances the level index on a win.
- Sits between the board buttons and the level instances; consumes each level's win/lose flags.

Parameters:
- NUM_LEVELS, 3, number of level instances; index 0 is played first.
- LIVES, 3, lives at game start; must be >= 1.
- LOAD_CYCLES, 4, cycles level_reset_n is held low in LOAD; must be >= 1.
- SETTLE_CYCLES, 2, cycles at PLAY entry during which win/lose are ignored.
- HOLD_CYCLES, 25_000_000, result-screen duration in vga_clock cycles (1 s at 25 MHz).

Ports:
- vga_clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; samples on the vga_clock rising edge.
- start_button  in  1  active-high level; only rising edges act (registered edge detect).
- level_win  in  1  win flag of the currently selected level.
- level_lose  in  1  lose flag of the currently selected level.
- level_select  out  $clog2(NUM_LEVELS)  index of the active level, for output muxing.
- level_reset_n  out  1  active-low reset to the selected level.
- screen_mode  out  2  0 = TITLE, 1 = PLAY (also LOAD), 2 = WIN, 3 = LOSE / GAME_OVER.
- lives  out  $clog2(LIVES+1)  remaining lives.
- game_won  out  1  high in VICTORY.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- States:
  - TITLE, LOAD, PLAY, WIN_HOLD, LOSE_HOLD, VICTORY, GAME_OVER.
  - All outputs are registered.
- Reset (at any time, including mid-LOAD or mid-HOLD):
  - State = TITLE, level_select = 0, lives = LIVES, level_reset_n = 0.
  - screen_mode = 0, game_won = 0, game_over = 0.
  - Timer = 0, start edge-detect register = 0.
- TITLE:
  - level_reset_n = 0.
  - A start rising edge → LOAD, timer cleared.
- LOAD:
  - level_reset_n = 0 for exactly LOAD_CYCLES cycles, then → PLAY.
  - level_reset_n goes to 1 on the same edge that enters PLAY.
  - screen_mode = 1.
- PLAY:
  - level_reset_n = 1.
  - For the first SETTLE_CYCLES cycles, win/lose are ignored.
  - After that, level_lose → LOSE_HOLD; otherwise level_win → WIN_HOLD.
  - Lose has priority when both are high in the same cycle.
  - start_button is ignored.
- WIN_HOLD:
  - screen_mode = 2, level_reset_n = 1 (level frozen by its own win flag).
  - After HOLD_CYCLES cycles: if level_select == NUM_LEVELS-1 → VICTORY; else level_select += 1 → LOAD.
- LOSE_HOLD:
  - lives decrements once, on the entry edge.
  - screen_mode = 3.
  - After HOLD_CYCLES cycles: lives == 0 → GAME_OVER; else → LOAD with the same level_select.
- VICTORY / GAME_OVER:
  - level_reset_n = 0; game_won or game_over = 1; screen_mode = 2 or 3 respectively.
  - A start rising edge → LOAD with level_select = 0 and lives = LIVES.
- Timer:
  - 32-bit up-counter, cleared on every state change; terminal count is HOLD_CYCLES-1 (LOAD_CYCLES-1 in LOAD).
  - HOLD_CYCLES = 1 gives a single-cycle hold.
- Lives never underflow: the decrement saturates at 0.
- level_select never exceeds NUM_LEVELS-1; there is no wrap.
- A start edge held across states acts once only: the edge is consumed by the transition.

Test Plan:
(bench params unless noted: NUM_LEVELS = 2, LIVES = 2, LOAD_CYCLES = 2, SETTLE_CYCLES = 2, HOLD_CYCLES = 8)
- Reset then start pulse:
  - level_reset_n is low for exactly 2 cycles after TITLE exit, then high.
  - screen_mode = 1, level_select = 0.
- Win in PLAY:
  - WIN_HOLD lasts 8 cycles, then LOAD with level_select = 1.
  - A second win → VICTORY, game_won = 1, level_reset_n = 0.
- Lose twice on level 0:
  - lives goes 2 → 1 → 0.
  - After the second hold → GAME_OVER, game_over = 1.
  - A start edge → LOAD, lives = 2, level_select = 0.
- level_win and level_lose high in the same cycle after settle → LOSE_HOLD; lives decrements by 1.
- win/lose asserted in the first 2 PLAY cycles then dropped → stays in PLAY; start held high for 20 cycles causes no transition.
- Synchronous reset asserted mid-WIN_HOLD on level 1 → next edge: TITLE, level_select = 0, lives = 2, timer = 0, all flags 0.
